digit_buffer_writer: RTL and testbench



---
 rtl/digit_buffer_writer.sv | 115 +++++++++++
 tb/tb_digit_buffer_writer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/digit_buffer_writer.sv
// Write side of the 8-digit display buffer: scroll-in writes, backspace, swept clear.
// Optional sticky overflow flag is built when DIGIT_BUFFER_OVERFLOW_FLAG_EN is defined.
module digit_buffer_writer #(
    parameter logic [4:0] BLANK_CODE = 5'd16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_cmd,
    input  logic [4:0] in_code,
    output logic [4:0] digit_0,
    output logic [4:0] digit_1,
    output logic [4:0] digit_2,
    output logic [4:0] digit_3,
    output logic [4:0] digit_4,
    output logic [4:0] digit_5,
    output logic [4:0] digit_6,
    output logic [4:0] digit_7,
    output logic [3:0] char_count,
    output logic       busy,
    output logic       overflow
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [1:0] CMD_WRITE = 2'b00;
    localparam logic [1:0] CMD_BKSP  = 2'b01;
    localparam logic [1:0] CMD_CLEAR = 2'b10;

    state_t           r_state;
    logic [7:0][4:0]  r_dig;
    logic [2:0]       r_idx;
    logic [3:0]       r_count;
    logic             w_accept;

    assign w_accept = in_valid && (r_state == S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_dig   <= {8{BLANK_CODE}};
            r_idx   <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (in_cmd)
                            CMD_WRITE: begin
                                r_dig <= {r_dig[6:0], in_code};
                                if (r_count != 4'd8)
                                    r_count <= r_count + 4'd1;
                            end
                            CMD_BKSP: begin
                                if (r_count != 4'd0) begin
                                    r_dig   <= {BLANK_CODE, r_dig[7:1]};
                                    r_count <= r_count - 4'd1;
                                end
                            end
                            CMD_CLEAR: begin
                                r_count <= '0;
                                r_idx   <= '0;
                                r_state <= S_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
                S_CLEAR: begin
                    // One digit per cycle, right to left; the edge blanking digit_7 ends the sweep.
                    r_dig[r_idx] <= BLANK_CODE;
                    r_idx        <= r_idx + 3'd1;
                    if (r_idx == 3'd7)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DIGIT_BUFFER_OVERFLOW_FLAG_EN
    logic r_overflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_overflow <= 1'b0;
        else if (w_accept && in_cmd == CMD_CLEAR)
            r_overflow <= 1'b0;
        else if (w_accept && in_cmd == CMD_WRITE && r_count == 4'd8)
            r_overflow <= 1'b1;
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

    assign in_ready   = (r_state == S_IDLE);
    assign busy       = (r_state == S_CLEAR);
    assign char_count = r_count;

    assign digit_0 = r_dig[0];
    assign digit_1 = r_dig[1];
    assign digit_2 = r_dig[2];
    assign digit_3 = r_dig[3];
    assign digit_4 = r_dig[4];
    assign digit_5 = r_dig[5];
    assign digit_6 = r_dig[6];
    assign digit_7 = r_dig[7];

endmodule

// File: tb/tb_digit_buffer_writer.sv
// Directed bench for digit_buffer_writer: vector table for write/backspace/reserved,
// hand sequences for the clear sweep and asynchronous reset mid-sweep.
module tb_digit_buffer_writer;

    localparam logic [4:0] B = 5'd16;
`ifdef DIGIT_BUFFER_OVERFLOW_FLAG_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_cmd;
    logic [4:0] in_code;
    logic [4:0] digit_0, digit_1, digit_2, digit_3;
    logic [4:0] digit_4, digit_5, digit_6, digit_7;
    logic [3:0] char_count;
    logic       busy;
    logic       overflow;

    digit_buffer_writer #(.BLANK_CODE(B)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cmd(in_cmd), .in_code(in_code),
        .digit_0(digit_0), .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3),
        .digit_4(digit_4), .digit_5(digit_5), .digit_6(digit_6), .digit_7(digit_7),
        .char_count(char_count), .busy(busy), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [1:0]  cmd;
        logic [4:0]  code;
        logic [39:0] exp_dig;
        logic [3:0]  exp_cnt;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [39:0] pk(input int d7, d6, d5, d4, d3, d2, d1, d0);
        return {5'(d7), 5'(d6), 5'(d5), 5'(d4), 5'(d3), 5'(d2), 5'(d1), 5'(d0)};
    endfunction

    function automatic vec_t mk(input logic v, input logic [1:0] c, input logic [4:0] k,
                                input logic [39:0] d, input logic [3:0] n, input logic o);
        vec_t r;
        r.valid = v; r.cmd = c; r.code = k; r.exp_dig = d; r.exp_cnt = n; r.exp_ovf = o;
        return r;
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [39:0] dig, input logic [3:0] cnt,
                           input logic rdy, input logic bsy, input logic ovf);
        logic [39:0] act;
        act = {digit_7, digit_6, digit_5, digit_4, digit_3, digit_2, digit_1, digit_0};
        for (int j = 0; j < 8; j++)
            chk($sformatf("%s digit_%0d", tag, j), 40'(act[j*5 +: 5]), 40'(dig[j*5 +: 5]));
        chk({tag, " char_count"}, 40'(char_count), 40'(cnt));
        chk({tag, " in_ready"}, 40'(in_ready), 40'(rdy));
        chk({tag, " busy"}, 40'(busy), 40'(bsy));
        chk({tag, " overflow"}, 40'(overflow), 40'(ovf));
    endtask

    task automatic step(input logic v, input logic [1:0] c, input logic [4:0] k);
        in_valid = v; in_cmd = c; in_code = k;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [39:0] d;
        logic [39:0] allb;
        allb = {8{B}};

        vecs.push_back(mk(1, 2'b00, 5'd1, pk(16,16,16,16,16,16,16,1), 4'd1, 0));
        vecs.push_back(mk(1, 2'b00, 5'd2, pk(16,16,16,16,16,16,1,2),  4'd2, 0));
        vecs.push_back(mk(1, 2'b00, 5'd3, pk(16,16,16,16,16,1,2,3),   4'd3, 0));
        vecs.push_back(mk(1, 2'b11, 5'd9, pk(16,16,16,16,16,1,2,3),   4'd3, 0));
        vecs.push_back(mk(1, 2'b01, 5'd7, pk(16,16,16,16,16,16,1,2),  4'd2, 0));
        vecs.push_back(mk(1, 2'b01, 5'd7, pk(16,16,16,16,16,16,16,1), 4'd1, 0));
        vecs.push_back(mk(1, 2'b01, 5'd7, allb, 4'd0, 0));
        vecs.push_back(mk(1, 2'b01, 5'd7, allb, 4'd0, 0));
        vecs.push_back(mk(0, 2'b00, 5'd7, allb, 4'd0, 0));
        for (int k = 0; k <= 8; k++) begin
            for (int j = 0; j < 8; j++)
                d[j*5 +: 5] = (k >= j) ? 5'(k - j) : B;
            vecs.push_back(mk(1, 2'b00, 5'(k), d, (k >= 7) ? 4'd8 : 4'(k + 1),
                              (k == 8) ? OVF_EN : 1'b0));
        end
        vecs.push_back(mk(1, 2'b01, 5'd0, pk(16,1,2,3,4,5,6,7), 4'd7, OVF_EN));
        vecs.push_back(mk(1, 2'b00, 5'd8, pk(1,2,3,4,5,6,7,8),  4'd8, OVF_EN));

        reset = 1'b1; in_valid = 1'b0; in_cmd = 2'b00; in_code = 5'd0;
        #2;
        chk_all("reset", allb, 4'd0, 1, 0, 0);
        #10;
        reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].valid, vecs[i].cmd, vecs[i].code);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_dig, vecs[i].exp_cnt, 1, 0, vecs[i].exp_ovf);
        end

        // Clear with a write held pending through the sweep
        step(1, 2'b10, 5'd0);
        chk_all("clr_accept", pk(1,2,3,4,5,6,7,8), 4'd0, 0, 1, 0);
        in_cmd = 2'b00; in_code = 5'd5;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            for (int j = 0; j < 8; j++)
                d[j*5 +: 5] = (j <= k) ? B : 5'(8 - j);
            chk_all($sformatf("sweep%0d", k), d, 4'd0, (k == 7), (k != 7), 0);
        end
        @(posedge clk);
        #1;
        chk_all("held_write", pk(16,16,16,16,16,16,16,5), 4'd1, 1, 0, 0);

        step(1, 2'b00, 5'd6);
        step(1, 2'b00, 5'd7);
        step(1, 2'b00, 5'd8);
        chk_all("prefill", pk(16,16,16,16,5,6,7,8), 4'd4, 1, 0, 0);

        // Asynchronous reset in the 4th cycle of a sweep
        step(1, 2'b10, 5'd0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("sweep_mid", pk(16,16,16,16,5,16,16,16), 4'd0, 0, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", allb, 4'd0, 1, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_all("post_rst", allb, 4'd0, 1, 0, 0);
        step(1, 2'b00, 5'd3);
        chk_all("post_rst_wr", pk(16,16,16,16,16,16,16,3), 4'd1, 1, 0, 0);
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
